cond_flag_unit: RTL and testbench

- Architectural NZCV flag register and condition-gating stage of the multi-cycle ARM control path.
- Sits directly upstream of the condition-evaluation block:
  - drives Flags[3:0] into it;
  - consumes its combinational CondEx result;
  - latches CondEx once per instruction.
- Uses the latched result to gate the main FSM's write strobes (PC, register file, memory, flags) for conditional instructions.

---
 rtl/cond_flag_unit.sv | 122 ++++++++++++
 tb/tb_cond_flag_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: architectural NZCV flag register plus condition gating of the
// multi-cycle control FSM write strobes.
//
// The condition evaluator's CondEx is captured once per instruction on CondLatch,
// and the captured value (CondExD) gates the PC, register-file, memory and flag
// writes. There is no combinational path from CondEx to any output.
//
// Optional build macro COND_PERF_CNT_EN adds the saturating counters ExecCnt and
// SquashCnt. Each InstrDone pulse increments one of them, depending on CondExD.
module cond_flag_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             CondEx,
    input  logic             CondLatch,
    input  logic             InstrDone,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
`ifdef COND_PERF_CNT_EN
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt,
`endif
    output logic [3:0]       Flags,
    output logic             CondExD,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite
);

    logic [3:0] flags_q;
    logic       cond_ex_q;
    logic       flag_w_nz;
    logic       flag_w_cv;

    // Flag writes are themselves conditional on the latched condition
    always_comb begin
        flag_w_nz = FlagW[1] & cond_ex_q;
        flag_w_cv = FlagW[0] & cond_ex_q;
    end

    // Condition latch: capture CondEx only in the Decode cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_ex_q <= 1'b0;
        end else if (CondLatch) begin
            cond_ex_q <= CondEx;
        end
    end

    // NZCV register with independent N,Z and C,V field enables
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            if (flag_w_nz) begin
                flags_q[3:2] <= ALUFlags[3:2];
            end
            if (flag_w_cv) begin
                flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Write-strobe gating from the registered condition; NextPC (fetch) is never gated
    always_comb begin
        Flags    = flags_q;
        CondExD  = cond_ex_q;
        PCWrite  = (PCS & cond_ex_q) | NextPC;
        RegWrite = RegW & cond_ex_q;
        MemWrite = MemW & cond_ex_q;
    end

`ifdef COND_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] exec_cnt_q;
    logic [CNT_W-1:0] exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q;
    logic [CNT_W-1:0] squash_cnt_d;

    // Next counter values; cond_ex_q is the pre-latch value when CondLatch coincides
    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (InstrDone) begin
            if (cond_ex_q) begin
                if (exec_cnt_q != CntMax) begin
                    exec_cnt_d = exec_cnt_q + CntOne;
                end
            end else begin
                if (squash_cnt_q != CntMax) begin
                    squash_cnt_d = squash_cnt_q + CntOne;
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    // Counter outputs
    always_comb begin
        ExecCnt   = exec_cnt_q;
        SquashCnt = squash_cnt_q;
    end
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed self-checking bench for cond_flag_unit.
// Counter scenarios are built only when COND_PERF_CNT_EN is defined.
module tb_cond_flag_unit;

    logic       clk;
    logic       reset;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       CondEx;
    logic       CondLatch;
    logic       InstrDone;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic [3:0] Flags;
    logic       CondExD;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
`ifdef COND_PERF_CNT_EN
    logic [1:0] ExecCnt;
    logic [1:0] SquashCnt;
`endif

    int n_cmp;
    int n_err;

    cond_flag_unit #(
        .CNT_W(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .CondEx   (CondEx),
        .CondLatch(CondLatch),
        .InstrDone(InstrDone),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
`ifdef COND_PERF_CNT_EN
        .ExecCnt  (ExecCnt),
        .SquashCnt(SquashCnt),
`endif
        .Flags    (Flags),
        .CondExD  (CondExD),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; ALUFlags = 4'b0000; FlagW = 2'b00; CondEx = 0; CondLatch = 0;
        InstrDone = 0; PCS = 0; NextPC = 0; RegW = 0; MemW = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic latch_cond(input logic c);
        CondLatch = 1; CondEx = c;
        tick();
        CondLatch = 0; CondEx = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; NextPC = 1; RegW = 1;
        tick();
        reset = 0;
        n_cmp++; if (Flags !== 4'b0000) begin n_err++;
            $display("FAIL reset_flags got=%b exp=0000", Flags); end
        n_cmp++; if (CondExD !== 1'b0) begin n_err++;
            $display("FAIL reset_condexd got=%b exp=0", CondExD); end
        n_cmp++; if (PCWrite !== 1'b1) begin n_err++;
            $display("FAIL reset_pcwrite got=%b exp=1", PCWrite); end
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++;
            $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
        n_cmp++; if (MemWrite !== 1'b0) begin n_err++;
            $display("FAIL reset_memwrite got=%b exp=0", MemWrite); end
        idle_inputs();
    endtask

    task automatic test_flag_write();
        do_reset();
        latch_cond(1'b1);
        n_cmp++; if (CondExD !== 1'b1) begin n_err++;
            $display("FAIL fw_condexd got=%b exp=1", CondExD); end
        FlagW = 2'b11; ALUFlags = 4'b1010;
        #1;
        n_cmp++; if (Flags !== 4'b0000) begin n_err++;
            $display("FAIL fw_before_edge got=%b exp=0000", Flags); end
        tick();
        FlagW = 2'b00; ALUFlags = 4'b0000;
        n_cmp++; if (Flags !== 4'b1010) begin n_err++;
            $display("FAIL fw_after_edge got=%b exp=1010", Flags); end
        // Executed instruction: all write strobes pass
        RegW = 1; MemW = 1; PCS = 1;
        #1;
        n_cmp++; if ({PCWrite, RegWrite, MemWrite} !== 3'b111) begin n_err++;
            $display("FAIL exec_gating got=%b exp=111", {PCWrite, RegWrite, MemWrite}); end
        idle_inputs();
    endtask

    task automatic test_squash();
        // Flags hold 1010 from previous test
        latch_cond(1'b0);
        n_cmp++; if (CondExD !== 1'b0) begin n_err++;
            $display("FAIL sq_condexd got=%b exp=0", CondExD); end
        FlagW = 2'b11; ALUFlags = 4'b0101; RegW = 1; MemW = 1; PCS = 1;
        #1;
        n_cmp++; if ({PCWrite, RegWrite, MemWrite} !== 3'b000) begin n_err++;
            $display("FAIL sq_gating got=%b exp=000", {PCWrite, RegWrite, MemWrite}); end
        NextPC = 1;
        #1;
        n_cmp++; if (PCWrite !== 1'b1) begin n_err++;
            $display("FAIL sq_nextpc got=%b exp=1", PCWrite); end
        tick();
        n_cmp++; if (Flags !== 4'b1010) begin n_err++;
            $display("FAIL sq_flags_hold got=%b exp=1010", Flags); end
        idle_inputs();
    endtask

    task automatic test_partial();
        do_reset();
        latch_cond(1'b1);
        FlagW = 2'b10; ALUFlags = 4'b0111;
        tick();
        n_cmp++; if (Flags !== 4'b0100) begin n_err++;
            $display("FAIL part_nz got=%b exp=0100", Flags); end
        FlagW = 2'b01; ALUFlags = 4'b1010;
        tick();
        n_cmp++; if (Flags !== 4'b0110) begin n_err++;
            $display("FAIL part_cv got=%b exp=0110", Flags); end
        idle_inputs();
    endtask

    task automatic test_cond_ignored();
        // CondExD=1; CondEx and InstrDone without CondLatch must not change state
        CondEx = 0; InstrDone = 1;
        tick();
        CondEx = 1;
        tick();
        CondEx = 0;
        tick();
        InstrDone = 0;
        n_cmp++; if (CondExD !== 1'b1) begin n_err++;
            $display("FAIL ign_condexd got=%b exp=1", CondExD); end
        n_cmp++; if (Flags !== 4'b0110) begin n_err++;
            $display("FAIL ign_flags got=%b exp=0110", Flags); end
        idle_inputs();
    endtask

    task automatic test_latch_old();
        // Latch cycle uses the old CondExD=1 for gating and flag enable
        CondLatch = 1; CondEx = 0; RegW = 1; FlagW = 2'b11; ALUFlags = 4'b1111;
        #1;
        n_cmp++; if (RegWrite !== 1'b1) begin n_err++;
            $display("FAIL old_regwrite got=%b exp=1", RegWrite); end
        tick();
        idle_inputs();
        n_cmp++; if (CondExD !== 1'b0) begin n_err++;
            $display("FAIL old_condexd got=%b exp=0", CondExD); end
        n_cmp++; if (Flags !== 4'b1111) begin n_err++;
            $display("FAIL old_flags got=%b exp=1111", Flags); end
        RegW = 1;
        #1;
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++;
            $display("FAIL old_after_regwrite got=%b exp=0", RegWrite); end
        idle_inputs();
    endtask

    task automatic test_reset_override();
        latch_cond(1'b1);
        reset = 1; CondLatch = 1; CondEx = 1; FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        idle_inputs();
        n_cmp++; if (CondExD !== 1'b0) begin n_err++;
            $display("FAIL rov_condexd got=%b exp=0", CondExD); end
        n_cmp++; if (Flags !== 4'b0000) begin n_err++;
            $display("FAIL rov_flags got=%b exp=0000", Flags); end
    endtask

`ifdef COND_PERF_CNT_EN
    task automatic test_counters();
        do_reset();
        n_cmp++; if ({ExecCnt, SquashCnt} !== 4'b0000) begin n_err++;
            $display("FAIL cnt_reset got=%b exp=0000", {ExecCnt, SquashCnt}); end
        latch_cond(1'b1);
        for (int i = 0; i < 5; i++) begin
            InstrDone = 1;
            tick();
            InstrDone = 0;
            tick();
        end
        n_cmp++; if (ExecCnt !== 2'd3) begin n_err++;
            $display("FAIL cnt_exec_sat got=%0d exp=3", ExecCnt); end
        latch_cond(1'b0);
        InstrDone = 1;
        tick();
        InstrDone = 0;
        n_cmp++; if (SquashCnt !== 2'd1) begin n_err++;
            $display("FAIL cnt_squash got=%0d exp=1", SquashCnt); end
        // Coincident with CondLatch: counts against old CondExD=0
        InstrDone = 1; CondLatch = 1; CondEx = 1;
        tick();
        idle_inputs();
        n_cmp++; if ({ExecCnt, SquashCnt} !== {2'd3, 2'd2}) begin n_err++;
            $display("FAIL cnt_coincident got=%0d/%0d exp=3/2", ExecCnt, SquashCnt); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        test_reset();
        test_flag_write();
        test_squash();
        test_partial();
        test_cond_ignored();
        test_latch_old();
        test_reset_override();
`ifdef COND_PERF_CNT_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
